fejkon_button: RTL and testbench

- Board-to-fabric counterpart of the LED driver: conditions the active-low board push-buttons into clean fabric-side status.
- Per channel: synchronizes the raw pin, debounces it, and produces a pressed level plus one-cycle press, release and long-press event pulses.
- Sits on the clk domain beside the LED block; consumers include port-reset logic and debug/status registers.

---
 rtl/fejkon_button.sv | 190 +++++++++++++++++++
 tb/tb_fejkon_button.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fejkon_button.sv
`default_nettype none
// ============================================================================
// Module      : fejkon_button
// Description : Conditions active-low board push-buttons into clean fabric
//               status. Each channel has a 2-flop synchronizer and a debounce
//               FSM. It drives a debounced pressed level and registered
//               one-cycle press, release and long-press pulses.
//               The release pulse port is named release_pulse because
//               "release" is a reserved SystemVerilog keyword.
//               Optional macro FEJKON_BUTTON_IRQ_EN adds irq, irq_ack and
//               event_pending. event_pending latches press/long-press events.
// Revision    : 1.0 - initial release
// ============================================================================
module fejkon_button #(
    parameter int REFERENCE_CLOCK = 50000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int LONG_PRESS_MS   = 1000,
    parameter int WIDTH           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] button_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press
`ifdef FEJKON_BUTTON_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] event_pending
`endif
);

    localparam int c_DEB_CYCLES  = (REFERENCE_CLOCK / 1000) * DEBOUNCE_MS;
    localparam int c_LONG_CYCLES = (REFERENCE_CLOCK / 1000) * LONG_PRESS_MS;
    localparam int c_CW          = $clog2(c_LONG_CYCLES + 1);

    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic [c_CW-1:0] c_DEB_MAX  = c_CW'(c_DEB_CYCLES);
    localparam logic [c_CW-1:0] c_LONG_MAX = c_CW'(c_LONG_CYCLES);
    localparam logic [c_CW-1:0] c_LONG_PRE = c_CW'(c_LONG_CYCLES - 1);

    localparam logic [1:0] c_ST_RELEASED   = 2'd0;
    localparam logic [1:0] c_ST_PRESS_PEND = 2'd1;
    localparam logic [1:0] c_ST_PRESSED    = 2'd2;
    localparam logic [1:0] c_ST_REL_PEND   = 2'd3;

    // A zero-length debounce window would accept every glitch.
    generate
        if (c_DEB_CYCLES < 1) begin : g_bad_debounce
            $error("fejkon_button: debounce window must be at least one clock");
        end
    endgenerate

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_raw;
    logic [1:0]       r_state    [WIDTH];
    logic [c_CW-1:0]  r_deb_cnt  [WIDTH];
    logic [c_CW-1:0]  r_hold_cnt [WIDTH];
    logic [WIDTH-1:0] r_pressed;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [WIDTH-1:0] r_long;

    // Buttons are active-low; the synchronizer idles at 1 so reset looks released.
    assign w_raw = ~r_sync2;

    // Two-flop synchronizer for the asynchronous board pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= button_n;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce FSM with hold timer and registered event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i]    <= c_ST_RELEASED;
                r_deb_cnt[i]  <= '0;
                r_hold_cnt[i] <= '0;
            end
            r_pressed <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                r_long[i]    <= 1'b0;

                // The hold timer runs while held, including during release
                // debounce, so a long press still fires through a bouncy release.
                if ((r_state[i] == c_ST_PRESSED) || (r_state[i] == c_ST_REL_PEND)) begin
                    if (r_hold_cnt[i] != c_LONG_MAX) begin
                        r_hold_cnt[i] <= r_hold_cnt[i] + c_ONE;
                        if (r_hold_cnt[i] == c_LONG_PRE) begin
                            r_long[i] <= 1'b1;
                        end
                    end
                end

                case (r_state[i])
                    c_ST_RELEASED: begin
                        if (w_raw[i]) begin
                            r_state[i]   <= c_ST_PRESS_PEND;
                            r_deb_cnt[i] <= c_ONE;
                        end
                    end
                    c_ST_PRESS_PEND: begin
                        if (!w_raw[i]) begin
                            r_state[i]   <= c_ST_RELEASED;
                            r_deb_cnt[i] <= '0;
                        end else if (r_deb_cnt[i] == c_DEB_MAX) begin
                            r_state[i]    <= c_ST_PRESSED;
                            r_deb_cnt[i]  <= '0;
                            r_hold_cnt[i] <= '0;
                            r_press[i]    <= 1'b1;
                            r_pressed[i]  <= 1'b1;
                        end else begin
                            r_deb_cnt[i] <= r_deb_cnt[i] + c_ONE;
                        end
                    end
                    c_ST_PRESSED: begin
                        if (!w_raw[i]) begin
                            r_state[i]   <= c_ST_REL_PEND;
                            r_deb_cnt[i] <= c_ONE;
                        end
                    end
                    default: begin
                        if (w_raw[i]) begin
                            r_state[i]   <= c_ST_PRESSED;
                            r_deb_cnt[i] <= '0;
                        end else if (r_deb_cnt[i] == c_DEB_MAX) begin
                            // Accepting the release overrides the hold timer,
                            // so long_press can never fire on or after this edge.
                            r_state[i]    <= c_ST_RELEASED;
                            r_deb_cnt[i]  <= '0;
                            r_hold_cnt[i] <= '0;
                            r_long[i]     <= 1'b0;
                            r_release[i]  <= 1'b1;
                            r_pressed[i]  <= 1'b0;
                        end else begin
                            r_deb_cnt[i] <= r_deb_cnt[i] + c_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign pressed       = r_pressed;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;

`ifdef FEJKON_BUTTON_IRQ_EN
    logic [WIDTH-1:0] r_event_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_irq;

    // An ack clears old events, but events arriving with the ack survive it.
    always_comb begin
        w_pending_nxt = (irq_ack ? '0 : r_event_pending) | r_press | r_long;
    end

    // Pending flags and the interrupt line update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_event_pending <= '0;
            r_irq           <= 1'b0;
        end else begin
            r_event_pending <= w_pending_nxt;
            r_irq           <= |w_pending_nxt;
        end
    end

    assign event_pending = r_event_pending;
    assign irq           = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fejkon_button.sv
`default_nettype none
// ============================================================================
// Module      : tb_fejkon_button
// Description : Directed self-checking bench for fejkon_button at 1 clk/ms,
//               4 ms debounce, 20 ms long press, 4 channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fejkon_button;

    logic       clk;
    logic       reset;
    logic [3:0] button_n;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] long_press;
`ifdef FEJKON_BUTTON_IRQ_EN
    logic       irq;
    logic       irq_ack;
    logic [3:0] event_pending;
`endif

    fejkon_button #(
        .REFERENCE_CLOCK(1000),
        .DEBOUNCE_MS    (4),
        .LONG_PRESS_MS  (20),
        .WIDTH          (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .button_n     (button_n),
        .pressed      (pressed),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press)
`ifdef FEJKON_BUTTON_IRQ_EN
        ,
        .irq          (irq),
        .irq_ack      (irq_ack),
        .event_pending(event_pending)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_press [4];
    int n_rel   [4];
    int n_long  [4];
    int t_press [4];
    int t_rel   [4];
    int t_long  [4];

    // Posedge index; a pulse seen at the following negedge belongs to edge cyc.
    always @(posedge clk) cyc = cyc + 1;

    // Pulse recorder sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press[i])         begin n_press[i] = n_press[i] + 1; t_press[i] = cyc; end
            if (release_pulse[i]) begin n_rel[i]   = n_rel[i] + 1;   t_rel[i]   = cyc; end
            if (long_press[i])    begin n_long[i]  = n_long[i] + 1;  t_long[i]  = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
            t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
        end
    endtask

    int c0;
    int cr;

    initial begin
        reset    = 1'b1;
        button_n = 4'hF;
`ifdef FEJKON_BUTTON_IRQ_EN
        irq_ack  = 1'b0;
`endif
        clr_counts();

        // Reset state
        step(3);
        chk("rst_pressed", pressed, 0);
        chk("rst_pulses", {press, release_pulse, long_press}, 0);
        reset = 1'b0;
        step(3);
        chk("idle_pressed", pressed, 0);

        // Clean press on channel 0: pulse exactly 6 edges after first sample
        clr_counts();
        button_n[0] = 1'b0;
        step(6);
        chk("clean_not_yet", pressed, 0);
        step(1);
        chk("clean_press_pulse", press, 4'b0001);
        chk("clean_pressed", pressed, 4'b0001);
        step(1);
        chk("clean_press_single", press, 0);

        // Glitch rejection on channel 1: 3 low cycles rejected
        clr_counts();
        button_n[1] = 1'b0;
        step(3);
        button_n[1] = 1'b1;
        step(12);
        chk("glitch_no_press", n_press[1], 0);
        chk("glitch_pressed", pressed[1], 0);
        // 5 low cycles: shortest pulse the FSM accepts, then a clean release
        clr_counts();
        c0 = cyc;
        button_n[1] = 1'b0;
        step(5);
        button_n[1] = 1'b1;
        step(12);
        chk("short_press_cnt", n_press[1], 1);
        chk("short_press_time", t_press[1], c0 + 7);
        chk("short_release_cnt", n_rel[1], 1);
        chk("short_release_time", t_rel[1], c0 + 12);

        // Bouncy release on channel 0 (still held from the clean press)
        clr_counts();
        c0 = 0;
        for (int k = 0; k < 5; k++) begin
            button_n[0] = 1'b1;
            c0 = cyc;
            step(2);
            if (k < 4) begin
                button_n[0] = 1'b0;
                step(2);
            end
        end
        step(10);
        chk("bounce_release_cnt", n_rel[0], 1);
        chk("bounce_release_time", t_rel[0], c0 + 7);
        chk("bounce_no_press", n_press[0], 0);
        chk("bounce_pressed", pressed[0], 0);

        // Long press on channel 3: held 30 ms
        clr_counts();
        c0 = cyc;
        button_n[3] = 1'b0;
        step(30);
        button_n[3] = 1'b1;
        step(12);
        chk("long_press_time", t_press[3], c0 + 7);
        chk("long_cnt", n_long[3], 1);
        chk("long_time", t_long[3], c0 + 27);
        chk("long_release_time", t_rel[3], c0 + 37);
        chk("long_other_ch", n_long[0] + n_long[1] + n_long[2], 0);

        // Simultaneous presses on channels 1 and 2
        clr_counts();
        c0 = cyc;
        button_n[2:1] = 2'b00;
        step(9);
        chk("simul_ch1", t_press[1], c0 + 7);
        chk("simul_ch2", t_press[2], c0 + 7);
        chk("simul_pressed", pressed, 4'b0110);

        // Reset mid-PRESS_PEND on ch0 and mid-PRESSED on ch1/ch2
        button_n[0] = 1'b0;
        step(4);
        clr_counts();
        reset = 1'b1;
        #1;
        chk("rst_async_pressed", pressed, 0);
        step(3);
        chk("rst_no_pulses", n_press[0] + n_press[1] + n_press[2] + n_rel[1] + n_rel[2], 0);
        reset = 1'b0;
        cr = cyc;
        step(10);
        chk("rst_repress_ch0", t_press[0], cr + 7);
        chk("rst_repress_ch2", t_press[2], cr + 7);
        chk("rst_repress_pressed", pressed, 4'b0111);
        // Reset again while all three are in PRESSED
        step(3);
        clr_counts();
        reset = 1'b1;
        #1;
        chk("rst2_async_pressed", pressed, 0);
        step(2);
        reset = 1'b0;
        cr = cyc;
        step(10);
        chk("rst2_repress_ch1", t_press[1], cr + 7);
        chk("rst2_no_release", n_rel[0] + n_rel[1] + n_rel[2], 0);

`ifdef FEJKON_BUTTON_IRQ_EN
        // Release everything, let it settle, then clear pending events
        button_n = 4'hF;
        step(30);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(1);
        chk("irq_cleared_pend", event_pending, 0);
        chk("irq_cleared", irq, 0);
        // Press ch2 -> pending bit 2 and irq
        button_n[2] = 1'b0;
        step(8);
        chk("irq_pend_ch2", event_pending, 4'b0100);
        chk("irq_set", irq, 1);
        // Ack during the press[0] pulse cycle: old bit cleared, new bit kept
        button_n[0] = 1'b0;
        step(7);
        chk("irq_ack_press0", press, 4'b0001);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("irq_ack_pend", event_pending, 4'b0001);
        chk("irq_ack_irq", irq, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
